// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified single-port RAM: CPU datapath (r0) vs loader/debug (r1).
// Define MEM_ARB_LOCK_EN to add the rN_lock ports and lock-owner state for atomic read-modify-write.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic [3:0]  r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic        r0_lock,
    input  logic        r1_lock,
`endif
    input  logic        r1_req,
    input  logic [3:0]  r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  o_dbg_wait_cnt,
    output logic [1:0]  o_dbg_lock
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_nxt;
    logic       r_rvalid_q;
    logic       r_rsel_q;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_lock_active;
    logic       w_lock_owner;

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic [1:0] {LK_NONE = 2'd0, LK_R0 = 2'd1, LK_R1 = 2'd2} lock_state_t;
    lock_state_t r_lock_state;
    lock_state_t w_lock_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lock_state <= LK_NONE;
        else        r_lock_state <= w_lock_nxt;
    end

    // Ownership drops when the owner stops requesting or takes an unlocked grant.
    always_comb begin
        w_lock_nxt = r_lock_state;
        case (r_lock_state)
            LK_NONE: begin
                if (w_gnt0 && r0_lock)      w_lock_nxt = LK_R0;
                else if (w_gnt1 && r1_lock) w_lock_nxt = LK_R1;
            end
            LK_R0: if (!r0_req || (w_gnt0 && !r0_lock)) w_lock_nxt = LK_NONE;
            LK_R1: if (!r1_req || (w_gnt1 && !r1_lock)) w_lock_nxt = LK_NONE;
            default: w_lock_nxt = LK_NONE;
        endcase
    end

    always_comb begin
        w_lock_active = (r_lock_state != LK_NONE);
        w_lock_owner  = (r_lock_state == LK_R1);
    end
`else
    assign w_lock_active = 1'b0;
    assign w_lock_owner  = 1'b0;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_lock_active) begin
            w_gnt0 = !w_lock_owner && r0_req;
            w_gnt1 = w_lock_owner && r1_req;
        end else if (r0_req && r1_req) begin
            if (r_wait_cnt == BURST_MAX) w_gnt1 = 1'b1;
            else                         w_gnt0 = 1'b1;
        end else begin
            w_gnt0 = r0_req;
            w_gnt1 = r1_req;
        end
    end

    always_comb begin
        mem_we    = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (w_gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (w_gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    // Counts r0 grants that overtook a waiting r1; frozen during a locked sequence.
    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (w_lock_active)                            w_wait_nxt = r_wait_cnt;
        else if (!r1_req || w_gnt1)                   w_wait_nxt = 4'd0;
        else if (w_gnt0 && (r_wait_cnt < BURST_MAX))  w_wait_nxt = r_wait_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
            r_rvalid_q <= 1'b0;
            r_rsel_q   <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            r_rvalid_q <= (w_gnt0 && (r0_we == 4'd0)) || (w_gnt1 && (r1_we == 4'd0));
            r_rsel_q   <= w_gnt1;
        end
    end

    assign r0_gnt         = w_gnt0;
    assign r1_gnt         = w_gnt1;
    assign r0_rvalid      = r_rvalid_q && !r_rsel_q;
    assign r1_rvalid      = r_rvalid_q && r_rsel_q;
    assign r0_rdata       = mem_rdata;
    assign r1_rdata       = mem_rdata;
    assign o_dbg_wait_cnt = r_wait_cnt;
    assign o_dbg_lock     = {w_lock_active, w_lock_owner};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus reset, back-to-back and lock sequences,
// with a registered RAM model and a queue of expected read returns.
module tb_mem_arbiter;

  typedef struct {
    logic        r0_req;
    logic [3:0]  r0_we;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_lock;
    logic        r1_req;
    logic [3:0]  r1_we;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_lock;
    logic        g0;
    logic        g1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req, r0_lock, r1_lock;
  logic [3:0]  r0_we, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  dbg_wait_cnt;
  logic [1:0]  dbg_lock;

  logic [31:0] ram [0:63];
  logic [31:0] shadow [0:63];
  logic [33:0] exp_q[$];
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
`ifdef MEM_ARB_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_dbg_wait_cnt(dbg_wait_cnt), .o_dbg_lock(dbg_lock)
  );

  // Single-port RAM with one-cycle registered read (read-before-write).
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= ram[mem_addr[7:2]];
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = init_word(i);
  end

  function automatic vec_t mk(input logic q0, input logic [3:0] we0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic q1, input logic [3:0] we1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.r0_req = q0; v.r0_we = we0; v.r0_addr = a0; v.r0_wdata = d0; v.r0_lock = 1'b0;
    v.r1_req = q1; v.r1_we = we1; v.r1_addr = a1; v.r1_wdata = d1; v.r1_lock = 1'b0;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    r0_req = v.r0_req; r0_we = v.r0_we; r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
    r0_lock = v.r0_lock;
    r1_req = v.r1_req; r1_we = v.r1_we; r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
    r1_lock = v.r1_lock;
  endtask

  task automatic check_ret(input string tag);
    logic [33:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'd0;
    chk({tag, " r0_rvalid"}, 32'(r0_rvalid), 32'(e[33]));
    chk({tag, " r1_rvalid"}, 32'(r1_rvalid), 32'(e[32]));
    if (e[33]) chk({tag, " r0_rdata"}, r0_rdata, e[31:0]);
    if (e[32]) chk({tag, " r1_rdata"}, r1_rdata, e[31:0]);
  endtask

  // One arbitration cycle: entered just after a rising edge, leaves just after the next one.
  task automatic cycle(input vec_t v, input string tag);
    logic [3:0]  ewe;
    logic [31:0] ea, ed;
    int          idx;
    drive(v);
    @(negedge clk);
    check_ret(tag);
    ewe = v.g0 ? v.r0_we : (v.g1 ? v.r1_we : 4'd0);
    ea  = v.g0 ? v.r0_addr : (v.g1 ? v.r1_addr : 32'd0);
    ed  = v.g0 ? v.r0_wdata : (v.g1 ? v.r1_wdata : 32'd0);
    chk({tag, " r0_gnt"}, 32'(r0_gnt), 32'(v.g0));
    chk({tag, " r1_gnt"}, 32'(r1_gnt), 32'(v.g1));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(ewe));
    chk({tag, " mem_addr"}, mem_addr, ea);
    chk({tag, " mem_wdata"}, mem_wdata, ed);
    idx = int'(ea[7:2]);
    if ((v.g0 || v.g1) && ewe == 4'd0)
      exp_q.push_back({v.g0, v.g1, shadow[idx]});
    else
      exp_q.push_back(34'd0);
    for (int b = 0; b < 4; b++)
      if (ewe[b]) shadow[idx][8*b +: 8] = ed[8*b +: 8];
    @(posedge clk);
    #1;
  endtask

  vec_t v;

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    rst_n = 1'b0;
    drive(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));

    // Reset: idle outputs, then a read held pending across reset.
    @(negedge clk);
    chk("rst r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    r0_req = 1'b1; r0_addr = 32'h10;
    repeat (2) begin
      @(negedge clk);
      chk("rst r0_rvalid", 32'(r0_rvalid), 32'd0);
      chk("rst r1_rvalid", 32'(r1_rvalid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    cycle(mk(1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0), "post_rst_read");

    // Vector table
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h20, 32'hDEADBEEF, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h20, 32'h0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h3, 32'h4, 32'h12345678, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h4, 32'h0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, 4'h0, 32'h30, 32'h0, 1, 4'h0, 32'h34, 32'h0, (k % 5) != 4, (k % 5) == 4));
    tbl.push_back(mk(1, 4'hF, 32'h40, 32'h0BADF00D, 1, 4'hF, 32'h44, 32'h11111111, 1, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h44, 32'h0, 0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 4'h0, 32'h40, 32'h0, 1, 4'h0, 32'h48, 32'h0, 1, 0));
    tbl.push_back(mk(1, 4'h0, 32'h40, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 4'h0, 32'h50, 32'h0, 1, 4'h0, 32'h48, 32'h0, k != 4, k == 4));
    tbl.push_back(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
    foreach (tbl[i]) cycle(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted the cycle after a read grant: the pending rvalid must vanish.
    cycle(mk(1, 4'h0, 32'h3C, 32'h0, 1, 4'h0, 32'h38, 32'h0, 1, 0), "pre_mid_rst");
    rst_n = 1'b0;
    drive(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
    @(negedge clk);
    chk("mid_rst r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("mid_rst r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("mid_rst wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    chk("mid_rst r0_gnt", 32'(r0_gnt), 32'd0);
    chk("mid_rst mem_we", 32'(mem_we), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0), "post_mid_rst");

`ifdef MEM_ARB_LOCK_EN
    // Locked read-modify-write by r0 while r1 keeps requesting.
    v = mk(1, 4'h0, 32'h8, 32'h0, 1, 4'h0, 32'h0C, 32'h0, 1, 0);
    v.r0_lock = 1'b1;
    cycle(v, "lock_rd");
    cycle(mk(1, 4'hF, 32'h8, 32'hCAFEF00D, 1, 4'h0, 32'h0C, 32'h0, 1, 0), "lock_wr");
    cycle(mk(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0C, 32'h0, 0, 1), "lock_release");
    cycle(mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0), "lock_idle");
`else
    v = mk(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    cycle(v, "final_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port unified RAM between the multicycle CPU datapath (requester 0) and a loader/debug port (requester 1). It sits between the CPU's address mux / B-register write path and the RAM instance. It grants one transfer per cycle, returns read data with the RAM's one-cycle latency, and bounds starvation of requester 1 with a burst counter.

## Interface
- `MAX_BURST`, default 4: consecutive requester-0 grants allowed while requester 1 waits (legal range 1–15).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `r0_req` / `r1_req`  in  1  transfer request; hold until granted.
- `r0_we` / `r1_we`  in  4  byte write enables; 0 = read.
- `r0_addr` / `r1_addr`  in  32  byte address.
- `r0_wdata` / `r1_wdata`  in  32  write data.
- `r0_lock` / `r1_lock`  in  1  hold ownership after this grant (only with `MEM_ARB_LOCK_EN`).
- `r0_gnt` / `r1_gnt`  out  1  transfer accepted this cycle; combinational.
- `r0_rvalid` / `r1_rvalid`  out  1  read data valid; registered.
- `r0_rdata` / `r1_rdata`  out  32  read data; both are `mem_rdata` passed through and qualified by the matching rvalid.
- `mem_we`  out  4  RAM byte write enables.
- `mem_addr`  out  32  RAM address.
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM read data; registered inside the RAM, valid one cycle after the address.

## Operation
- Grant selection each cycle, evaluated in this order:
  - Lock owner active: the lock owner gets the grant if it requests. Otherwise there is no grant.
  - Only one requester: that requester is granted.
  - Both requesting and `wait_cnt` == `MAX_BURST`: requester 1 is granted.
  - Both requesting otherwise: requester 0 is granted.
- At most one gnt is high in any cycle.
- Muxing:
  - `mem_*` carries the granted requester's `we`/`addr`/`wdata`.
  - With no grant: `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Burst counter `wait_cnt` (4 bits):
  - Increments on each r0 grant while `r1_req` is high, saturating at `MAX_BURST`.
  - Clears on an r1 grant, and on any cycle where `r1_req` is low.
  - Holds while a lock is active.
- Read return:
  - A granted cycle with `we` == 0 sets the `rvalid_q` flag and the `rsel_q` owner flag.
  - Next cycle, the corresponding rN_rvalid = 1 for exactly one cycle.
  - Write grants never produce rvalid.
- Back-to-back operation:
  - A read grant in cycle N followed by any grant in N+1 is legal.
  - The rvalid for the read in N appears in N+1, concurrent with the N+1 grant.
- Reset:
  - The asynchronous assert clears `wait_cnt`, `rvalid_q`, `rsel_q` and the lock owner.
  - Outputs during and after reset: all gnt = 0 while requests are low, all rvalid = 0, `mem_we` = 0.
  - A read in flight when reset asserts produces no rvalid.

## Timing
- Request to grant: 0 cycles. `rN_req` → `rN_gnt` → `mem_*` is combinational, and the transfer commits at the same rising edge.
- Read latency: rvalid and rdata arrive 1 cycle after the granted cycle.
- Throughput: 1 transfer per cycle. No dead cycles when switching owner.
- Worst-case requester-1 wait: `MAX_BURST` cycles while requester 0 requests continuously, with no lock active.
- The CPU treats `r0_gnt` low as a stall. It holds its PC, IR and ALUOut enables until granted.

## Configuration
- `MEM_ARB_LOCK_EN` defined: the `rN_lock` ports exist.
  - A grant with `rN_lock` = 1 makes N the lock owner.
  - Ownership releases on a grant to N with lock = 0, or on any cycle where `rN_req` = 0.
  - The other requester is blocked while N owns the lock; this supports atomic read-modify-write.
- `MEM_ARB_LOCK_EN` undefined: the lock ports and lock owner register are absent, and behaviour equals lock tied to 0.

## Test plan
- Reset, then a read: reset with `r0_req` = 1, `r0_addr` = 0x10, `we` = 0 → no rvalid during reset. After release: `r0_gnt` = 1 in the first cycle, `r0_rvalid` = 1 with `r0_rdata` = RAM[0x10] in the next cycle.
- Single write then read: r1 writes 0xDEADBEEF to 0x20 with `we` = 4'b1111 → `mem_we` = 4'b1111 for one cycle and no rvalid. An r1 read of 0x20 then returns 0xDEADBEEF one cycle later.
- Contention fairness: both request continuously, `MAX_BURST` = 4 → grant pattern r0,r0,r0,r0,r1,r0,r0,r0,r0,r1… Never two gnt high at once.
- Back-to-back mixed: r0 reads 0x0 in cycle N and r1 writes 0x4 in N+1 → `r0_rvalid` in N+1 concurrent with `r1_gnt`. `r1_rvalid` stays 0.
- Reset mid-read: `rst_n` asserted in the cycle after a read grant → `r0_rvalid` = 0, `wait_cnt` = 0.
- Lock (`MEM_ARB_LOCK_EN`): r0 reads 0x8 with lock = 1, then writes 0x8 with lock = 0, while r1 requests throughout → r1 has no grant in either cycle and is granted in the cycle after the unlocked write.
